n_bit_up_counter: RTL and testbench

//   Free-running modulo-MOD_VALUE binary up counter with a synchronous,

---
 rtl/n_bit_up_counter.sv | 35 +++
 tb/tb_n_bit_up_counter.sv | 109 ++++++++++
 2 files changed

// File: rtl/n_bit_up_counter.sv
// Modulo-MOD_VALUE binary up counter with a synchronous active-low clear.
// Counts 0 .. MOD_VALUE-1, wraps to 0, one step per rising clk edge.
// The output is taken straight from the count register.
module n_bit_up_counter #(
   parameter  int MOD_VALUE = 8,
   localparam int W         = (MOD_VALUE < 2) ? 1 : $clog2(MOD_VALUE)
) (
   input  logic         clk,
   input  logic         rstn,
   output logic [W-1:0] out
);

   // Terminal count; the wrap happens here, not at the natural 2^W-1 overflow.
   localparam logic [W-1:0] LAST = W'(MOD_VALUE - 1);

   // Reject a modulus that cannot form a counter at elaboration time.
   if (MOD_VALUE < 2) begin : g_bad_mod
      $error("n_bit_up_counter: MOD_VALUE must be >= 2 (got %0d)", MOD_VALUE);
   end

   // Count register: clear takes priority, otherwise advance and wrap at LAST.
   // NOTE: rstn is only looked at on the clock edge, so a low pulse that starts
   // and ends between edges leaves the count untouched. State updates use <=
   // so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         out <= '0;
      end else if (out == LAST) begin
         out <= '0;
      end else begin
         out <= out + 1'b1;
      end
   end

endmodule

// File: tb/tb_n_bit_up_counter.sv
// Bench for n_bit_up_counter: three instances (moduli 8, 6 and 2) share one
// clock, each with its own clear. Expected values are pushed to per-instance
// queues when stimulus is applied and popped after the following rising edge.
module tb_n_bit_up_counter;

   logic       clk = 1'b0;
   logic       rstn8, rstn6, rstn2;
   logic [2:0] out8;
   logic [2:0] out6;
   logic [0:0] out2;

   int compared   = 0;
   int mismatched = 0;

   int q8[$];
   int q6[$];
   int q2[$];

   // Reference state of each counter as the bench believes it to be.
   int m8 = 0;
   int m6 = 0;
   int m2 = 0;

   always #5 clk = ~clk;

   n_bit_up_counter #(.MOD_VALUE(8)) u_mod8 (.clk(clk), .rstn(rstn8), .out(out8));
   n_bit_up_counter #(.MOD_VALUE(6)) u_mod6 (.clk(clk), .rstn(rstn6), .out(out6));
   n_bit_up_counter #(.MOD_VALUE(2)) u_mod2 (.clk(clk), .rstn(rstn2), .out(out2));

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int model_next(input int cur, input int modv, input logic r);
      if (!r) return 0;
      return (cur + 1) % modv;
   endfunction

   task automatic pop_check(input string tag, inout int q[$], input logic [31:0] observed,
                            input int modv);
      int exp_v;
      if (q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         exp_v = q.pop_front();
         check(tag, observed, exp_v);
         check({tag, "_range"}, {31'd0, observed < modv}, 32'd1);
      end
   endtask

   // Apply one cycle of stimulus away from the edge, predict, then compare
   // one time unit after the rising edge.
   task automatic cycle(input logic r8, input logic r6, input logic r2);
      rstn8 = r8;
      rstn6 = r6;
      rstn2 = r2;
      m8 = model_next(m8, 8, r8);
      m6 = model_next(m6, 6, r6);
      m2 = model_next(m2, 2, r2);
      q8.push_back(m8);
      q6.push_back(m6);
      q2.push_back(m2);
      @(posedge clk);
      #1;
      pop_check("mod8", q8, {29'd0, out8}, 8);
      pop_check("mod6", q6, {29'd0, out6}, 6);
      pop_check("mod2", q2, {31'd0, out2}, 2);
      @(negedge clk);
   endtask

   initial begin
      // Reset held for two edges on every instance.
      repeat (2) cycle(1'b0, 1'b0, 1'b0);

      // Count and wrap: mod8 sees 1..7,0,1,2; mod6 sees 1..5,0,1,2 within the
      // first eight; mod2 toggles.
      repeat (10) cycle(1'b1, 1'b1, 1'b1);

      // Bring mod8 to 3, then clear it for five edges and release for three.
      cycle(1'b1, 1'b1, 1'b1);
      check("mod8_at_3", {29'd0, out8}, 32'd3);
      repeat (5) cycle(1'b0, 1'b1, 1'b1);
      repeat (3) cycle(1'b1, 1'b1, 1'b1);

      // A short low pulse between edges must not clear anything.
      rstn8 = 1'b0;
      rstn6 = 1'b0;
      rstn2 = 1'b0;
      #2;
      rstn8 = 1'b1;
      rstn6 = 1'b1;
      rstn2 = 1'b1;
      repeat (4) cycle(1'b1, 1'b1, 1'b1);

      // Clear each instance at a different point, then let all run on.
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0);
      repeat (12) cycle(1'b1, 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
